// File: rtl/rx_seq_num_checker_pkg.sv
// Shared constants, FSM encoding and status bit positions for the receive-side MsgSeqNum checker.
// Status is carried as a one-hot vector indexed by the SEQ_STS_* constants.
package rx_seq_num_checker_pkg;

    localparam int HOST_ADDR_WIDTH = 8;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_ERR     = 3'd2,
        ST_COMPARE = 3'd3,
        ST_REPORT  = 3'd4
    } state_e;

    localparam int SEQ_STS_OK  = 0;
    localparam int SEQ_STS_DUP = 1;
    localparam int SEQ_STS_GAP = 2;
    localparam int SEQ_STS_LOW = 3;
    localparam int SEQ_STS_FMT = 4;
    localparam int SEQ_STS_W   = 5;

endpackage

// File: rtl/rx_seq_num_checker_ascii_to_binary.sv
// ASCII decimal digit accumulator: acc = acc*10 + digit, with non-digit, overflow and digit-count checks.
// i_clear restarts the field; a byte presented with i_clear is applied on top of the cleared state.
module rx_seq_num_checker_ascii_to_binary
    import rx_seq_num_checker_pkg::*;
#(
    parameter int SEQ_WIDTH  = 32,
    parameter int MAX_DIGITS = 10,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_digit_vld,
    input  logic [7:0]           i_digit,
    output logic [SEQ_WIDTH-1:0] o_value,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_err,
    output logic                 o_step_err
);

    localparam int ACC_W = SEQ_WIDTH + 4;

    logic [SEQ_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;

    logic [SEQ_WIDTH-1:0] w_base_acc;
    logic [CNT_W-1:0]     w_base_cnt;
    logic                 w_base_err;
    logic                 w_is_digit;
    logic [3:0]           w_nibble;
    logic [ACC_W-1:0]     w_prod;
    logic [CNT_W:0]       w_cnt_next;

    assign w_base_acc = i_clear ? '0 : r_acc;
    assign w_base_cnt = i_clear ? '0 : r_cnt;
    assign w_base_err = i_clear ? 1'b0 : r_err;

    assign w_is_digit = (i_digit >= ASCII_ZERO) && (i_digit <= ASCII_NINE);
    assign w_nibble   = 4'(i_digit - ASCII_ZERO);

    // Widened by 4 bits so any carry out of SEQ_WIDTH is visible as overflow.
    assign w_prod     = ({4'b0000, w_base_acc} << 3) + ({4'b0000, w_base_acc} << 1) + ACC_W'(w_nibble);
    assign w_cnt_next = {1'b0, w_base_cnt} + (CNT_W + 1)'(1);

    assign o_step_err = i_digit_vld &&
                        (!w_is_digit ||
                         (w_prod[ACC_W-1 -: 4] != 4'd0) ||
                         (w_cnt_next > (CNT_W + 1)'(MAX_DIGITS)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_clear || i_digit_vld) begin
            if (i_digit_vld && !o_step_err) begin
                r_acc <= w_prod[SEQ_WIDTH-1:0];
                r_cnt <= w_cnt_next[CNT_W-1:0];
            end else begin
                r_acc <= w_base_acc;
                r_cnt <= w_base_cnt;
            end
            r_err <= w_base_err || o_step_err;
        end
    end

    assign o_value = r_acc;
    assign o_count = r_cnt;
    assign o_err   = r_err;

endmodule

// File: rtl/rx_seq_num_checker.sv
// Decodes a received MsgSeqNum digit stream and classifies it against the host's expected number.
// Result and counter-update pulse appear two cycles after the terminator; start_i always restarts.
module rx_seq_num_checker
    import rx_seq_num_checker_pkg::*;
#(
    parameter int SEQ_WIDTH  = 32,
    parameter int MAX_DIGITS = 10,
    parameter int HOST_ADDR  = HOST_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [HOST_ADDR-1:0] received_host_addr_i,
    input  logic [SEQ_WIDTH-1:0] expected_seq_num_i,
    input  logic                 poss_dup_i,
    input  logic                 digit_valid_i,
    input  logic [7:0]           digit_i,
    input  logic                 end_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [SEQ_WIDTH-1:0] seq_num_o,
    output logic                 seq_ok_o,
    output logic                 seq_dup_o,
    output logic                 seq_gap_o,
    output logic                 seq_low_o,
    output logic                 format_err_o,
    output logic                 update_seq_counter_o,
    output logic [HOST_ADDR-1:0] seq_counter_loc_o,
    output logic [SEQ_WIDTH-1:0] new_seq_num_o
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_e r_state;
    state_e w_next;

    logic                 w_digit_take;
    logic                 w_end_take;
    logic                 w_step_err;
    logic                 w_a2b_err;
    logic                 w_fmt_err;
    logic [SEQ_WIDTH-1:0] w_value;
    logic [CNT_W-1:0]     w_count;
    logic [SEQ_STS_W-1:0] w_status;

    logic [HOST_ADDR-1:0] r_host;
    logic [SEQ_WIDTH-1:0] r_expected;
    logic                 r_poss_dup;
    logic                 r_done;
    logic                 r_update;
    logic [SEQ_STS_W-1:0] r_status;
    logic [SEQ_WIDTH-1:0] r_seq_num;
    logic [HOST_ADDR-1:0] r_loc;
    logic [SEQ_WIDTH-1:0] r_new_seq;

    // A digit arriving with start_i belongs to the new field.
    assign w_digit_take = digit_valid_i && (start_i || (r_state == ST_ACCUM));
    assign w_end_take   = end_i && (start_i || (r_state == ST_ACCUM) || (r_state == ST_ERR));

    rx_seq_num_checker_ascii_to_binary #(
        .SEQ_WIDTH  (SEQ_WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) u_a2b (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (start_i),
        .i_digit_vld (w_digit_take),
        .i_digit     (digit_i),
        .o_value     (w_value),
        .o_count     (w_count),
        .o_err       (w_a2b_err),
        .o_step_err  (w_step_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (start_i) begin
            if (end_i)           w_next = ST_COMPARE;
            else if (w_step_err) w_next = ST_ERR;
            else                 w_next = ST_ACCUM;
        end else begin
            unique case (r_state)
                ST_IDLE:    w_next = ST_IDLE;
                ST_ACCUM: begin
                    if (end_i)           w_next = ST_COMPARE;
                    else if (w_step_err) w_next = ST_ERR;
                end
                ST_ERR:     if (end_i) w_next = ST_COMPARE;
                ST_COMPARE: w_next = ST_REPORT;
                ST_REPORT:  w_next = ST_IDLE;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    assign w_fmt_err = w_a2b_err || (w_count == '0) || (w_value == '0);

    always_comb begin
        w_status = '0;
        if (w_fmt_err)                 w_status[SEQ_STS_FMT] = 1'b1;
        else if (w_value == r_expected) w_status[SEQ_STS_OK]  = 1'b1;
        else if (w_value > r_expected)  w_status[SEQ_STS_GAP] = 1'b1;
        else if (r_poss_dup)            w_status[SEQ_STS_DUP] = 1'b1;
        else                            w_status[SEQ_STS_LOW] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_host     <= '0;
            r_expected <= '0;
            r_poss_dup <= 1'b0;
            r_done     <= 1'b0;
            r_update   <= 1'b0;
            r_status   <= '0;
            r_seq_num  <= '0;
            r_loc      <= '0;
            r_new_seq  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_update <= 1'b0;
            if (w_end_take) begin
                r_poss_dup <= poss_dup_i;
            end
            if (start_i) begin
                r_host     <= received_host_addr_i;
                r_expected <= expected_seq_num_i;
                r_status   <= '0;
                r_seq_num  <= '0;
                r_loc      <= '0;
                r_new_seq  <= '0;
            end else if (r_state == ST_COMPARE) begin
                r_done    <= 1'b1;
                r_status  <= w_status;
                r_seq_num <= w_value;
                if (w_status[SEQ_STS_OK]) begin
                    r_update  <= 1'b1;
                    r_loc     <= r_host;
                    r_new_seq <= w_value + SEQ_WIDTH'(1);
                end
            end
        end
    end

    assign busy_o               = (r_state != ST_IDLE);
    assign done_o               = r_done;
    assign seq_num_o            = r_seq_num;
    assign seq_ok_o             = r_status[SEQ_STS_OK];
    assign seq_dup_o            = r_status[SEQ_STS_DUP];
    assign seq_gap_o            = r_status[SEQ_STS_GAP];
    assign seq_low_o            = r_status[SEQ_STS_LOW];
    assign format_err_o         = r_status[SEQ_STS_FMT];
    assign update_seq_counter_o = r_update;
    assign seq_counter_loc_o    = r_loc;
    assign new_seq_num_o        = r_new_seq;

endmodule

// File: tb/tb_rx_seq_num_checker.sv
// Scoreboard bench for rx_seq_num_checker: expected results are queued as fields are driven
// and compared when done_o pulses.
module tb_rx_seq_num_checker;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  received_host_addr_i;
    logic [31:0] expected_seq_num_i;
    logic        poss_dup_i;
    logic        digit_valid_i;
    logic [7:0]  digit_i;
    logic        end_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] seq_num_o;
    logic        seq_ok_o;
    logic        seq_dup_o;
    logic        seq_gap_o;
    logic        seq_low_o;
    logic        format_err_o;
    logic        update_seq_counter_o;
    logic [7:0]  seq_counter_loc_o;
    logic [31:0] new_seq_num_o;

    rx_seq_num_checker dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_i              (start_i),
        .received_host_addr_i (received_host_addr_i),
        .expected_seq_num_i   (expected_seq_num_i),
        .poss_dup_i           (poss_dup_i),
        .digit_valid_i        (digit_valid_i),
        .digit_i              (digit_i),
        .end_i                (end_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .seq_num_o            (seq_num_o),
        .seq_ok_o             (seq_ok_o),
        .seq_dup_o            (seq_dup_o),
        .seq_gap_o            (seq_gap_o),
        .seq_low_o            (seq_low_o),
        .format_err_o         (format_err_o),
        .update_seq_counter_o (update_seq_counter_o),
        .seq_counter_loc_o    (seq_counter_loc_o),
        .new_seq_num_o        (new_seq_num_o)
    );

    // bit 0 ok, 1 dup, 2 gap, 3 low, 4 format error
    logic [4:0] sts_vec;
    assign sts_vec = {format_err_o, seq_low_o, seq_gap_o, seq_dup_o, seq_ok_o};

    typedef struct {
        logic [4:0]  sts;
        logic [31:0] num;
        bit          chk_num;
        logic        upd;
        logic [7:0]  loc;
        logic [31:0] newv;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    logic [4:0] last_sts = '0;
    logic prev_upd = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input string s, input logic [31:0] exp, input logic pd,
                                   input logic [7:0] host, input int due);
        exp_t m;
        longint unsigned v = 0;
        bit bad = (s.len() == 0) || (s.len() > 10);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            if (c < 8'h30 || c > 8'h39) bad = 1;
            else v = v * 10 + longint'(c - 8'h30);
        end
        if (v > 64'hFFFF_FFFF || v == 0) bad = 1;
        m.num = v[31:0]; m.chk_num = !bad; m.upd = 1'b0; m.loc = '0; m.newv = '0; m.due = due;
        if (bad)                  m.sts = 5'b10000;
        else if (v[31:0] == exp) begin
            m.sts = 5'b00001; m.upd = 1'b1; m.loc = host; m.newv = v[31:0] + 32'd1;
        end
        else if (v[31:0] > exp)  m.sts = 5'b00100;
        else if (pd)             m.sts = 5'b00010;
        else                     m.sts = 5'b01000;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (update_seq_counter_o) begin
                check_eq("upd_with_done", 64'(done_o), 64'd1);
                check_eq("upd_pulse", 64'(prev_upd), 64'd0);
            end
            if (done_o) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check_eq("done_unexpected", 64'(done_o), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("status", 64'(sts_vec), 64'(e.sts));
                    if (e.chk_num) check_eq("seq_num", 64'(seq_num_o), 64'(e.num));
                    check_eq("update", 64'(update_seq_counter_o), 64'(e.upd));
                    check_eq("loc", 64'(seq_counter_loc_o), 64'(e.loc));
                    check_eq("new_seq", 64'(new_seq_num_o), 64'(e.newv));
                    check_eq("latency", 64'(cyc), 64'(e.due));
                    last_sts = e.sts;
                end
            end
        end
        prev_upd = update_seq_counter_o;
    end

    task automatic send_field(input string s, input logic [31:0] exp, input logic [7:0] host,
                              input logic pd, input bit dig_with_start, input bit end_with_last);
        int n = s.len();
        int i = 0;
        @(negedge clk);
        start_i = 1'b1; expected_seq_num_i = exp; received_host_addr_i = host;
        if (dig_with_start && n > 1) begin
            digit_valid_i = 1'b1; digit_i = s[0]; i = 1;
        end
        @(negedge clk);
        start_i = 1'b0; digit_valid_i = 1'b0;
        check_eq("busy", 64'(busy_o), 64'd1);
        while (i < n) begin
            digit_valid_i = 1'b1; digit_i = s[i]; i++;
            if (i == n && end_with_last) begin
                end_i = 1'b1; poss_dup_i = pd;
                sb.push_back(model(s, exp, pd, host, cyc + 2));
            end
            @(negedge clk);
            digit_valid_i = 1'b0; end_i = 1'b0;
        end
        if (!end_with_last || n == 0) begin
            end_i = 1'b1; poss_dup_i = pd;
            sb.push_back(model(s, exp, pd, host, cyc + 2));
            @(negedge clk);
            end_i = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("hold", 64'(sts_vec), 64'(last_sts));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; start_i = 1'b0; received_host_addr_i = '0; expected_seq_num_i = '0;
        poss_dup_i = 1'b0; digit_valid_i = 1'b0; digit_i = '0; end_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", 64'({done_o, busy_o, update_seq_counter_o}), 64'd0);
        check_eq("rst_status", 64'(sts_vec), 64'd0);
        check_eq("rst_seq_num", 64'(seq_num_o), 64'd0);
        check_eq("rst_loc", 64'(seq_counter_loc_o), 64'd0);
        check_eq("rst_new", 64'(new_seq_num_o), 64'd0);
        rst = 1'b0;

        // In-sequence, gap, low and duplicate
        send_field("41", 32'd41, 8'h05, 1'b0, 0, 0); wait_done();
        send_field("45", 32'd41, 8'h05, 1'b0, 0, 0); wait_done();
        send_field("7",  32'd41, 8'h05, 1'b0, 0, 0); wait_done();
        send_field("7",  32'd41, 8'h05, 1'b1, 0, 0); wait_done();

        // Malformed fields
        send_field("4A2",         32'd42, 8'h11, 1'b0, 0, 0); wait_done();
        send_field("0",           32'd1,  8'h11, 1'b0, 0, 0); wait_done();
        send_field("",            32'd1,  8'h11, 1'b0, 0, 0); wait_done();
        send_field("00000000012", 32'd12, 8'h11, 1'b0, 0, 0); wait_done();
        send_field("4294967296",  32'd5,  8'h11, 1'b0, 0, 0); wait_done();

        // Boundary values and framing variants
        send_field("4294967295", 32'hFFFF_FFFF, 8'h22, 1'b0, 0, 0); wait_done();
        send_field("007",        32'd7,         8'h23, 1'b0, 0, 0); wait_done();
        send_field("123",        32'd123,       8'h24, 1'b0, 0, 1); wait_done();
        send_field("56",         32'd56,        8'h25, 1'b0, 1, 0); wait_done();

        // Restart mid-field: only the second field reports
        d0 = done_cnt;
        @(negedge clk);
        start_i = 1'b1; expected_seq_num_i = 32'd3; received_host_addr_i = 8'h02;
        @(negedge clk);
        start_i = 1'b0; digit_valid_i = 1'b1; digit_i = 8'h31;
        @(negedge clk);
        digit_i = 8'h32;
        @(negedge clk);
        digit_valid_i = 1'b0;
        send_field("9", 32'd9, 8'h0C, 1'b0, 0, 0); wait_done();
        check_eq("abort_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Back-to-back: second start lands in the REPORT cycle of the first
        send_field("100", 32'd100, 8'h31, 1'b0, 0, 0);
        send_field("99",  32'd100, 8'h32, 1'b1, 0, 0);
        wait_done();

        // Reset mid-field
        d0 = done_cnt;
        @(negedge clk);
        start_i = 1'b1; expected_seq_num_i = 32'd12; received_host_addr_i = 8'h44;
        @(negedge clk);
        start_i = 1'b0; digit_valid_i = 1'b1; digit_i = 8'h31;
        @(negedge clk);
        digit_i = 8'h32;
        @(negedge clk);
        digit_valid_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ctrl", 64'({done_o, busy_o, update_seq_counter_o}), 64'd0);
        check_eq("midrst_status", 64'(sts_vec), 64'd0);
        rst = 1'b0; end_i = 1'b1;
        @(negedge clk);
        end_i = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("midrst_idle", 64'(busy_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
